// File: rtl/seg_pkg.sv
// Shared types and constants for multi-digit BCD display counters.
package seg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    REPEAT,
    WAIT_REL,
    LOCKOUT
  } state_e;

  typedef enum logic {
    DIR_INC,
    DIR_DEC
  } dir_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // Two-digit BCD value as held by the counter.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

endpackage

// File: rtl/bcd2_step.sv
// Combinational two-digit BCD +1 / -1 with wrap (99->00, 00->99).
module bcd2_step
  import seg_pkg::*;
(
  input  logic [3:0] i_tens,
  input  logic [3:0] i_ones,
  input  dir_e       i_dir,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  // Ones digit rolls over and carries/borrows into tens, which also wraps.
  always_comb begin
    o_tens = i_tens;
    o_ones = i_ones;
    if (i_dir == DIR_INC) begin
      if (i_ones >= BCD_MAX) begin
        o_ones = BCD_MIN;
        o_tens = (i_tens >= BCD_MAX) ? BCD_MIN : i_tens + 4'd1;
      end else begin
        o_ones = i_ones + 4'd1;
      end
    end else begin
      if (i_ones == BCD_MIN) begin
        o_ones = BCD_MAX;
        o_tens = (i_tens == BCD_MIN) ? BCD_MAX : i_tens - 4'd1;
      end else begin
        o_ones = i_ones - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_updown_repeat_counter.sv
// Two-digit BCD up/down counter with press edge detection, hold delay and
// auto-repeat. Conflicting switch activity parks the FSM in LOCKOUT until
// both switches are released.
module bcd_updown_repeat_counter
  import seg_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 12500000,
  parameter int unsigned REPEAT_CYCLES = 2500000,
  parameter bit          AUTO_REPEAT   = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_Inc,
  input  logic       i_Switch_Dec,
  output logic [3:0] o_Tens,
  output logic [3:0] o_Ones,
  output logic       o_Step,
  output logic       o_Busy
);

  localparam int unsigned TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int          TW      = $clog2(TMR_MAX);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  state_e        state_q, state_d;
  dir_e          dir_q, dir_d;
  logic [TW-1:0] tmr_q, tmr_d;
  bcd2_t         cnt_q, cnt_d;
  logic          step_q, step_d;
  logic          prev_inc_q, prev_dec_q;

  logic          press_inc, press_dec;
  logic          act_lvl, opp_lvl;
  dir_e          press_dir, step_dir;
  logic [3:0]    nxt_tens, nxt_ones;

  assign press_inc = i_Switch_Inc & ~prev_inc_q;
  assign press_dec = i_Switch_Dec & ~prev_dec_q;
  assign act_lvl   = (dir_q == DIR_INC) ? i_Switch_Inc : i_Switch_Dec;
  assign opp_lvl   = (dir_q == DIR_INC) ? i_Switch_Dec : i_Switch_Inc;
  assign press_dir = press_inc ? DIR_INC : DIR_DEC;
  // A fresh press picks the direction; repeats reuse the latched one.
  assign step_dir  = (state_q == IDLE) ? press_dir : dir_q;

  bcd2_step u_step (
    .i_tens (cnt_q.tens),
    .i_ones (cnt_q.ones),
    .i_dir  (step_dir),
    .o_tens (nxt_tens),
    .o_ones (nxt_ones)
  );

  // Next-state, timer and step decision; release beats opposite switch beats expiry.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    tmr_d   = tmr_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_inc && !i_Switch_Dec) begin
          step_d  = 1'b1;
          dir_d   = DIR_INC;
          tmr_d   = '0;
          state_d = AUTO_REPEAT ? HOLD : WAIT_REL;
        end else if (press_dec && !i_Switch_Inc) begin
          step_d  = 1'b1;
          dir_d   = DIR_DEC;
          tmr_d   = '0;
          state_d = AUTO_REPEAT ? HOLD : WAIT_REL;
        end else if (press_inc || press_dec) begin
          state_d = LOCKOUT;
        end
      end
      HOLD, REPEAT: begin
        if (!act_lvl) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (opp_lvl) begin
          state_d = LOCKOUT;
          tmr_d   = '0;
        end else if (tmr_q == ((state_q == HOLD) ? HOLD_LAST : REP_LAST)) begin
          step_d  = 1'b1;
          tmr_d   = '0;
          state_d = REPEAT;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      WAIT_REL: begin
        if (!act_lvl)     state_d = IDLE;
        else if (opp_lvl) state_d = LOCKOUT;
      end
      LOCKOUT: begin
        if (!i_Switch_Inc && !i_Switch_Dec) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
    cnt_d = step_d ? bcd2_t'{tens: nxt_tens, ones: nxt_ones} : cnt_q;
  end

  // State, count and switch history; history resets high so a held switch is ignored.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= IDLE;
      dir_q      <= DIR_INC;
      tmr_q      <= '0;
      cnt_q      <= '0;
      step_q     <= 1'b0;
      prev_inc_q <= 1'b1;
      prev_dec_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      tmr_q      <= tmr_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      prev_inc_q <= i_Switch_Inc;
      prev_dec_q <= i_Switch_Dec;
    end
  end

  assign o_Tens = cnt_q.tens;
  assign o_Ones = cnt_q.ones;
  assign o_Step = step_q;
  assign o_Busy = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_updown_repeat_counter.sv
// Scoreboard bench: a count-level reference model predicts steps and per-cycle
// outputs; a monitor pops predictions as the DUT presents them.
module tb_bcd_updown_repeat_counter;

  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       sw_inc = 1'b0, sw_dec = 1'b0;
  logic       sw_inc_b = 1'b0, sw_dec_b = 1'b0;
  logic [3:0] o_Tens, o_Ones, o_Tens_b, o_Ones_b;
  logic       o_Step, o_Busy, o_Step_b, o_Busy_b;

  bcd_updown_repeat_counter #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .AUTO_REPEAT(1'b1)) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch_Inc(sw_inc), .i_Switch_Dec(sw_dec),
    .o_Tens(o_Tens), .o_Ones(o_Ones), .o_Step(o_Step), .o_Busy(o_Busy));

  bcd_updown_repeat_counter #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .AUTO_REPEAT(1'b0)) dut_b (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch_Inc(sw_inc_b), .i_Switch_Dec(sw_dec_b),
    .o_Tens(o_Tens_b), .o_Ones(o_Ones_b), .o_Step(o_Step_b), .o_Busy(o_Busy_b));

  always #5 i_Clk = ~i_Clk;

  int cyc = 0;
  always @(posedge i_Clk) cyc <= cyc + 1;

  typedef struct { int en; int tens; int ones; } step_rec_t;
  typedef struct { int en; int busy; int tens; int ones; } obs_rec_t;
  step_rec_t step_q[$];
  obs_rec_t  obs_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: count 0..99, the active hold (direction, press edge) and a lock flag.
  int m_cnt, m_act, m_lock, m_press_edge;
  logic m_prev_inc, m_prev_dec;

  task automatic model_reset();
    m_cnt = 0; m_act = 0; m_lock = 0; m_press_edge = 0;
    m_prev_inc = 1'b1; m_prev_dec = 1'b1;
    step_q.delete(); obs_q.delete();
  endtask

  task automatic model_edge(input logic a, input logic b);
    int e, age;
    bit step, pi, pd, act_lvl, opp;
    e = cyc + 1; step = 0;
    pi = a && !m_prev_inc;
    pd = b && !m_prev_dec;
    act_lvl = (m_act > 0) ? a : b;
    opp     = (m_act > 0) ? b : a;
    if (m_act != 0) begin
      if (!act_lvl) m_act = 0;
      else if (opp) begin m_act = 0; m_lock = 1; end
      else begin
        age = e - m_press_edge;
        if (age >= HOLD && (age - HOLD) % REP == 0) step = 1;
      end
    end else if (m_lock != 0) begin
      if (!a && !b) m_lock = 0;
    end else if (pi && !b) begin
      m_act = 1; m_press_edge = e; step = 1;
    end else if (pd && !a) begin
      m_act = -1; m_press_edge = e; step = 1;
    end else if (pi || pd) begin
      m_lock = 1;
    end
    if (step) begin
      m_cnt = (m_cnt + m_act + 100) % 100;
      step_q.push_back('{e, m_cnt / 10, m_cnt % 10});
    end
    m_prev_inc = a; m_prev_dec = b;
    obs_q.push_back('{e, (m_act != 0 || m_lock != 0) ? 1 : 0, m_cnt / 10, m_cnt % 10});
  endtask

  // Monitor: pops step predictions when o_Step appears, per-cycle outputs each edge.
  always @(posedge i_Clk) begin
    #1;
    if (step_q.size() > 0 && step_q[0].en < cyc) begin
      chk("step_missed_at_edge", cyc, step_q[0].en);
      void'(step_q.pop_front());
    end
    if (o_Step) begin
      if (step_q.size() == 0) chk("step_unexpected", int'(o_Step), 0);
      else begin
        step_rec_t r;
        r = step_q.pop_front();
        chk("step_edge", cyc, r.en);
        chk("step_tens", int'(o_Tens), r.tens);
        chk("step_ones", int'(o_Ones), r.ones);
      end
    end
    while (obs_q.size() > 0 && obs_q[0].en < cyc) void'(obs_q.pop_front());
    if (obs_q.size() > 0 && obs_q[0].en == cyc) begin
      obs_rec_t o;
      o = obs_q.pop_front();
      chk("busy", int'(o_Busy), o.busy);
      chk("tens", int'(o_Tens), o.tens);
      chk("ones", int'(o_Ones), o.ones);
    end
  end

  task automatic drive(input logic a, input logic b);
    sw_inc = a; sw_dec = b;
    model_edge(a, b);
    @(negedge i_Clk);
  endtask

  task automatic drive_n(input logic a, input logic b, input int n);
    for (int i = 0; i < n; i++) drive(a, b);
  endtask

  task automatic do_reset(input logic hold_inc);
    i_Rst_L = 1'b0; sw_inc = hold_inc; sw_dec = 1'b0;
    model_reset();
    repeat (2) @(negedge i_Clk);
    chk("rst_tens", int'(o_Tens), 0);
    chk("rst_ones", int'(o_Ones), 0);
    chk("rst_step", int'(o_Step), 0);
    chk("rst_busy", int'(o_Busy), 0);
    i_Rst_L = 1'b1;
  endtask

  task automatic press(input logic a, input logic b, input int n);
    for (int i = 0; i < n; i++) begin drive(a, b); drive(1'b0, 1'b0); end
  endtask

  initial begin
    int nb;
    logic a, b;
    @(negedge i_Clk);
    // Three 3-cycle Inc pulses from reset.
    do_reset(1'b0);
    drive_n(0, 0, 2);
    for (int i = 0; i < 3; i++) begin drive_n(1, 0, 3); drive_n(0, 0, 3); end
    chk("count_after_3_presses", int'(o_Tens) * 10 + int'(o_Ones), 3);
    // Wrap boundaries: 03 -> 99, 99 -> 00 -> 99, up to 10, down to 09.
    press(0, 1, 4);
    press(1, 0, 1);
    press(0, 1, 1);
    press(1, 0, 11);
    press(0, 1, 1);
    chk("count_after_borrow", int'(o_Tens) * 10 + int'(o_Ones), 9);
    // Hold 21 edges from 00: steps at k, k+8, k+12, k+16, k+20.
    do_reset(1'b0);
    drive_n(0, 0, 2);
    drive_n(1, 0, 21);
    drive_n(0, 0, 6);
    chk("count_after_hold", int'(o_Tens) * 10 + int'(o_Ones), 5);
    // Simultaneous press -> lockout; releasing one at a time; then normal press.
    drive_n(1, 1, 3);
    drive_n(0, 1, 3);
    drive_n(0, 0, 2);
    press(1, 0, 1);
    // Into REPEAT then opposite switch.
    drive_n(1, 0, 15);
    drive_n(1, 1, 4);
    drive_n(1, 0, 3);
    drive_n(0, 0, 2);
    // Inc held across reset release.
    do_reset(1'b1);
    drive_n(1, 0, 5);
    drive_n(0, 0, 1);
    drive_n(1, 0, 2);
    drive_n(0, 0, 2);
    // Async reset in REPEAT right after the step to 37.
    do_reset(1'b0);
    drive_n(0, 0, 2);
    press(1, 0, 34);
    drive_n(1, 0, 13);
    chk("pre_rst_count", int'(o_Tens) * 10 + int'(o_Ones), m_cnt);
    chk("pre_rst_step", int'(o_Step), 1);
    #2 i_Rst_L = 1'b0;
    #1;
    chk("async_rst_tens", int'(o_Tens), 0);
    chk("async_rst_ones", int'(o_Ones), 0);
    chk("async_rst_step", int'(o_Step), 0);
    chk("async_rst_busy", int'(o_Busy), 0);
    do_reset(1'b0);
    drive_n(0, 0, 2);
    // Non-repeating instance: 50 cycles held gives one step.
    nb = 0;
    sw_inc_b = 1'b1;
    for (int i = 0; i < 50; i++) begin
      drive(0, 0);
      if (o_Step_b) nb++;
    end
    sw_inc_b = 1'b0;
    drive_n(0, 0, 2);
    chk("norep_step_count", nb, 1);
    chk("norep_ones", int'(o_Ones_b), 1);
    chk("norep_busy", int'(o_Busy_b), 0);
    // Randomized sticky switch levels.
    a = 1'b0; b = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) a = ~a;
      if ($urandom_range(11) == 0) b = ~b;
      drive(a, b);
    end
    drive_n(0, 0, 4);
    chk("step_queue_drained", step_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
